// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: shared state encodings and sizing constants for the shift-add multiplier.
package shift_add_multiplier_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int WIDTH  = 4;
    localparam int CYCLES = 4;
endpackage

// File: rtl/shift_add_multiplier_rca.sv
// ripple_carry_adder: WIDTH-bit ripple-carry adder with carry in and carry out.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    logic [WIDTH:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign c_out = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier, one add-and-shift step per RUN cycle.
module shift_add_multiplier #(
    parameter int WIDTH = shift_add_multiplier_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    import shift_add_multiplier_pkg::*;
    localparam int CW = $clog2(CYCLES);
    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] p;
    logic [2*WIDTH:0] p_sum;
    logic [2*WIDTH:0] p_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             last;
    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (mcand),
        .c_in (1'b0),
        .sum  (sum),
        .c_out(cout)
    );
    // The carry lands in p[2*WIDTH] before the shift so it is never lost.
    assign p_sum  = p[0] ? {cout, sum, p[WIDTH-1:0]} : p;
    assign p_next = {1'b0, p_sum[2*WIDTH:1]};
    assign last   = count == CW'(CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            p       <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        p     <= {{(WIDTH+1){1'b0}}, b};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p     <= p_next;
                    count <= count + 1'b1;
                    if (last) begin
                        product <= p_next[2*WIDTH-1:0];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed scenarios plus a shuffled exhaustive sweep against a*b.
module tb_shift_add_multiplier;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] product;
    logic       busy;
    logic       done;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_prod = 8'h00;
    int         order[256];

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .product(product),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start at a negedge; returns at the negedge of the first IDLE cycle after DONE.
    task automatic mul(input logic [3:0] x, input logic [3:0] y, input bit hold);
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (hold) begin
                a = 4'hF;
                b = 4'hF;
            end else begin
                start = 1'b0;
                a = 4'($urandom);
                b = 4'($urandom);
            end
            if (k == 5) exp_prod = 8'(int'(x) * int'(y));
            check($sformatf("busy %0d*%0d c%0d", x, y, k), busy, k <= 4);
            check($sformatf("done %0d*%0d c%0d", x, y, k), done, k == 5);
            check($sformatf("product %0d*%0d c%0d", x, y, k), product, exp_prod);
        end
        @(negedge clk);
        start = 1'b0;
        check($sformatf("idle busy %0d*%0d", x, y), busy, 0);
        check($sformatf("idle done %0d*%0d", x, y), done, 0);
        check($sformatf("idle product %0d*%0d", x, y), product, exp_prod);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        a = 4'd5;
        b = 4'd5;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        rst = 1'b0;
        start = 1'b0;
        mul(4'd15, 4'd15, 1'b0);
        check("max product", product, 8'hE1);
        mul(4'd0, 4'd13, 1'b0);
        mul(4'd11, 4'd0, 1'b0);
        mul(4'd9, 4'd6, 1'b0);
        mul(4'd7, 4'd5, 1'b0);
        mul(4'd3, 4'd4, 1'b1);
        @(negedge clk);
        check("held start ignored busy", busy, 0);
        check("held start product", product, 8'h0C);
        // Abort in the second RUN cycle.
        start = 1'b1;
        a = 4'd12;
        b = 4'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort run1 busy", busy, 1);
        @(negedge clk);
        check("abort run2 busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_prod = 8'h00;
        check("abort busy", busy, 0);
        check("abort product", product, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abort no done c%0d", k), done, 0);
            check($sformatf("abort no busy c%0d", k), busy, 0);
        end
        mul(4'd12, 4'd10, 1'b0);
        check("after abort product", product, 8'h78);
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            int gap;
            mul(4'(order[i] >> 4), 4'(order[i]), 1'b0);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                a = 4'($urandom);
                b = 4'($urandom);
                @(negedge clk);
                check("gap product hold", product, exp_prod);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
